// File: rtl/fwht_pkg.sv
// rtl/fwht_pkg.sv - shared constants and index maps for the FWHT pipeline
package fwht_pkg;

    localparam int FWHT_WIDTH = 16;
    localparam int FWHT_LGN   = 3;

    // Natural-order position of the sample emitted at sequency k: Gray code, then bit reversal.
    function automatic int unsigned walsh_index(input int unsigned k, input int unsigned lgn);
        int unsigned g;
        int unsigned r;
        g = k ^ (k >> 1);
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < lgn) begin
                r = r | (((g >> i) & 32'd1) << (lgn - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// rtl/reorder_ram.sv - simple dual-port RAM, one write port and one registered read port
module reorder_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fwht_reorder.sv
// rtl/fwht_reorder.sv - double-buffered output reorder for the SDF FWHT pipeline
module fwht_reorder
    import fwht_pkg::*;
#(
    parameter int WIDTH = FWHT_WIDTH,
    parameter int LGN   = FWHT_LGN,
    parameter int ORDER = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_last,
    output logic             o_busy
);

    localparam logic [0:0]     ST_IDLE = 1'b0;
    localparam logic [0:0]     ST_READ = 1'b1;
    localparam logic [LGN-1:0] K_LAST  = '1;

    logic [LGN-1:0] wcnt_q, wcnt_d;
    logic [LGN-1:0] rcnt_q, rcnt_d;
    logic           wbank_q, wbank_d;
    logic           rbank_q, rbank_d;
    logic [0:0]     state_q, state_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           start;
    logic [LGN-1:0] rmap;

    always_comb begin
        start   = i_valid && (wcnt_q == K_LAST);
        wcnt_d  = i_valid ? wcnt_q + LGN'(1) : wcnt_q;
        wbank_d = start ? ~wbank_q : wbank_q;
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_READ;
                rcnt_d  = '0;
                rbank_d = wbank_q;
            end
        end else if (rcnt_q == K_LAST) begin
            rcnt_d = '0;
            // A block finishing on the last read cycle chains straight into the next burst.
            if (start) begin
                rbank_d = wbank_q;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            rcnt_d = rcnt_q + LGN'(1);
        end
        valid_d = (state_q == ST_READ);
        last_d  = (state_q == ST_READ) && (rcnt_q == K_LAST);
    end

    always_comb begin
        if (ORDER != 0) begin
            rmap = LGN'(walsh_index(32'(rcnt_q), LGN));
        end else begin
            rmap = rcnt_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    reorder_ram #(
        .WIDTH (WIDTH),
        .AW    (LGN + 1)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (i_valid),
        .i_waddr ({wbank_q, wcnt_q}),
        .i_wdata (i_data),
        .i_re    (state_q == ST_READ),
        .i_raddr ({rbank_q, rmap}),
        .o_rdata (o_data)
    );

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q == ST_READ) || valid_q;

endmodule

// File: tb/tb_fwht_reorder.sv
// tb/tb_fwht_reorder.sv - randomized self-checking bench for fwht_reorder
module tb_fwht_reorder;

    localparam int W   = 16;
    localparam int LGN = 3;
    localparam int N   = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] data;
        logic        last;
    } rec_t;

    logic          i_clk   = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [W-1:0]  i_data  = '0;
    logic [W-1:0]  o_data_s, o_data_n;
    logic          o_valid_s, o_valid_n, o_last_s, o_last_n, o_busy_s, o_busy_n;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    rec_t exp_s[$], exp_n[$], obs_s[$], obs_n[$];
    logic [15:0] blk[$];
    logic busy_log[4096];
    int   walsh_src[N];

    fwht_reorder #(.WIDTH(W), .LGN(LGN), .ORDER(1)) u_dut_s (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data_s), .o_valid(o_valid_s), .o_last(o_last_s), .o_busy(o_busy_s)
    );

    fwht_reorder #(.WIDTH(W), .LGN(LGN), .ORDER(0)) u_dut_n (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data_n), .o_valid(o_valid_n), .o_last(o_last_n), .o_busy(o_busy_n)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin : monitor
        rec_t r;
        busy_log[cyc % 4096] = o_busy_s;
        if (o_valid_s === 1'b1) begin
            r.cyc = 32'(cyc); r.data = o_data_s; r.last = o_last_s;
            obs_s.push_back(r);
        end
        if (o_valid_n === 1'b1) begin
            r.cyc = 32'(cyc); r.data = o_data_n; r.last = o_last_n;
            obs_n.push_back(r);
        end
    end

    // Sequency of Hadamard row h = number of sign changes along the row.
    function automatic int sign_changes(input int h);
        int c = 0;
        for (int x = 1; x < N; x++) begin
            if (($countones(h & x) % 2) != ($countones(h & (x - 1)) % 2)) c++;
        end
        return c;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d);
        rec_t r;
        @(posedge i_clk); #1;
        i_valid = v;
        i_data  = d;
        if (v) begin
            blk.push_back(d);
            if (blk.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    r.cyc  = 32'(cyc + 2 + k);
                    r.last = (k == N - 1);
                    r.data = blk[walsh_src[k]];
                    exp_s.push_back(r);
                    r.data = blk[k];
                    exp_n.push_back(r);
                end
                blk.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
    endtask

    task automatic do_reset(output int r);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        r = cyc;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        blk.delete();
        while (exp_s.size() > 0 && exp_s[$].cyc > 32'(r)) void'(exp_s.pop_back());
        while (exp_n.size() > 0 && exp_n[$].cyc > 32'(r)) void'(exp_n.pop_back());
    endtask

    task automatic clear_logs();
        exp_s.delete(); exp_n.delete(); obs_s.delete(); obs_n.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        n_vec += 8;
        if (o_valid_s !== 1'b0 || o_valid_n !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b/%b want 0", o_valid_s, o_valid_n); end
        if (o_last_s !== 1'b0 || o_last_n !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b/%b want 0", o_last_s, o_last_n); end
        if (o_busy_s !== 1'b0 || o_busy_n !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0", o_busy_s, o_busy_n); end
        if (o_data_s !== '0 || o_data_n !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0", o_data_s, o_data_n); end
        n_err += 0;
        clear_logs();
    endtask

    task automatic test_sequency();
        int t;
        logic exp_busy;
        logic [15:0] tbl [N];
        tbl = '{16'd0, 16'd4, 16'd6, 16'd2, 16'd3, 16'd7, 16'd5, 16'd1};
        for (int i = 0; i < N; i++) drive(1'b1, 16'(i));
        t = cyc;
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != N || obs_n.size() != N) begin n_err++; $display("FAIL seq_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), N); end
        for (int i = 0; i < N && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== {32'(t + 2 + i), tbl[i], (i == N - 1)}) begin
                n_err++; $display("FAIL seq_out[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, t + 2 + i, tbl[i], i == N - 1);
            end
            if (obs_n[i] !== exp_n[i]) begin
                n_err++; $display("FAIL seq_nat[%0d]: got data=%0d want %0d", i, obs_n[i].data, exp_n[i].data);
            end
        end
        for (int c = t; c <= t + N + 2; c++) begin
            exp_busy = (c >= t + 1) && (c <= t + N + 1);
            n_vec++;
            if (busy_log[c % 4096] !== exp_busy) begin n_err++; $display("FAIL busy@t+%0d: got %b want %b", c - t, busy_log[c % 4096], exp_busy); end
        end
        clear_logs();
    endtask

    task automatic test_natural();
        int t;
        for (int i = 0; i < N; i++) drive(1'b1, 16'(10 + i));
        t = cyc;
        idle(N + 4);
        n_vec++;
        if (obs_n.size() != N || obs_s.size() != N) begin n_err++; $display("FAIL nat_count: got %0d/%0d want %0d", obs_n.size(), obs_s.size(), N); end
        for (int i = 0; i < N && i < obs_n.size() && i < obs_s.size(); i++) begin
            n_vec += 2;
            if (obs_n[i] !== {32'(t + 2 + i), 16'(10 + i), (i == N - 1)}) begin
                n_err++; $display("FAIL nat_out[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d", i, obs_n[i].cyc, obs_n[i].data, obs_n[i].last, t + 2 + i, 10 + i);
            end
            if (obs_s[i] !== exp_s[i]) begin
                n_err++; $display("FAIL nat_seq[%0d]: got data=%0d want %0d", i, obs_s[i].data, exp_s[i].data);
            end
        end
        clear_logs();
    endtask

    task automatic test_gapped();
        int sent = 0;
        int ph = 0;
        while (sent < N) begin
            if (ph == 0) begin drive(1'b1, 16'(sent)); sent++; end
            else drive(1'b0, 16'($urandom));
            ph = (ph + 1) % 3;
        end
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != exp_s.size() || obs_n.size() != exp_n.size()) begin n_err++; $display("FAIL gap_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), exp_s.size()); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== exp_s[i]) begin n_err++; $display("FAIL gap_seq[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, exp_s[i].cyc, exp_s[i].data, exp_s[i].last); end
            if (obs_n[i] !== exp_n[i]) begin n_err++; $display("FAIL gap_nat[%0d]: got cyc=%0d data=%0d want cyc=%0d data=%0d", i, obs_n[i].cyc, obs_n[i].data, exp_n[i].cyc, exp_n[i].data); end
        end
        clear_logs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * N; i++) drive(1'b1, 16'(i));
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != 3 * N || obs_n.size() != 3 * N) begin n_err++; $display("FAIL b2b_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), 3 * N); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== exp_s[i]) begin n_err++; $display("FAIL b2b_seq[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, exp_s[i].cyc, exp_s[i].data, exp_s[i].last); end
            if (obs_n[i] !== exp_n[i]) begin n_err++; $display("FAIL b2b_nat[%0d]: got cyc=%0d data=%0d want cyc=%0d data=%0d", i, obs_n[i].cyc, obs_n[i].data, exp_n[i].cyc, exp_n[i].data); end
        end
        if (obs_s.size() > N + 1) begin
            n_vec++;
            if (obs_s[N].data !== 16'd8 || obs_s[N + 1].data !== 16'd12) begin n_err++; $display("FAIL b2b_swap: got %0d,%0d want 8,12", obs_s[N].data, obs_s[N + 1].data); end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid_burst();
        int r;
        for (int i = 0; i < N; i++) drive(1'b1, 16'(i));
        idle(4);
        do_reset(r);
        @(negedge i_clk);
        n_vec++;
        if (o_valid_s !== 1'b0 || o_last_s !== 1'b0 || o_busy_s !== 1'b0) begin
            n_err++; $display("FAIL rst_burst_outs: got v=%b l=%b b=%b want 0", o_valid_s, o_last_s, o_busy_s);
        end
        for (int i = 0; i < N; i++) drive(1'b1, 16'(i));
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != exp_s.size() || obs_n.size() != exp_n.size()) begin n_err++; $display("FAIL rst_burst_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), exp_s.size()); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== exp_s[i]) begin n_err++; $display("FAIL rst_burst_seq[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, exp_s[i].cyc, exp_s[i].data, exp_s[i].last); end
            if (obs_n[i] !== exp_n[i]) begin n_err++; $display("FAIL rst_burst_nat[%0d]: got cyc=%0d data=%0d want cyc=%0d data=%0d", i, obs_n[i].cyc, obs_n[i].data, exp_n[i].cyc, exp_n[i].data); end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid_fill();
        int r;
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(100 + i));
        do_reset(r);
        for (int i = 0; i < N; i++) drive(1'b1, 16'(20 + i));
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != N || obs_n.size() != N) begin n_err++; $display("FAIL rst_fill_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), N); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== exp_s[i]) begin n_err++; $display("FAIL rst_fill_seq[%0d]: got cyc=%0d data=%0d last=%b want cyc=%0d data=%0d last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, exp_s[i].cyc, exp_s[i].data, exp_s[i].last); end
            if (obs_n[i] !== exp_n[i]) begin n_err++; $display("FAIL rst_fill_nat[%0d]: got cyc=%0d data=%0d want cyc=%0d data=%0d", i, obs_n[i].cyc, obs_n[i].data, exp_n[i].cyc, exp_n[i].data); end
        end
        clear_logs();
    endtask

    task automatic test_random();
        int sent = 0;
        while (sent < 5 * N) begin
            if ($urandom_range(0, 2) != 0) begin drive(1'b1, 16'($urandom)); sent++; end
            else drive(1'b0, 16'($urandom));
        end
        idle(N + 4);
        n_vec++;
        if (obs_s.size() != 5 * N || obs_n.size() != 5 * N) begin n_err++; $display("FAIL rand_count: got %0d/%0d want %0d", obs_s.size(), obs_n.size(), 5 * N); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size() && i < obs_n.size(); i++) begin
            n_vec += 2;
            if (obs_s[i] !== exp_s[i]) begin n_err++; $display("FAIL rand_seq[%0d]: got cyc=%0d data=%h last=%b want cyc=%0d data=%h last=%b", i, obs_s[i].cyc, obs_s[i].data, obs_s[i].last, exp_s[i].cyc, exp_s[i].data, exp_s[i].last); end
            if (obs_n[i] !== exp_n[i]) begin n_err++; $display("FAIL rand_nat[%0d]: got cyc=%0d data=%h want cyc=%0d data=%h", i, obs_n[i].cyc, obs_n[i].data, exp_n[i].cyc, exp_n[i].data); end
        end
        clear_logs();
    endtask

    initial begin
        for (int h = 0; h < N; h++) walsh_src[sign_changes(h)] = h;
        test_reset();
        test_sequency();
        test_natural();
        test_gapped();
        test_back_to_back();
        test_reset_mid_burst();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwht_reorder.md
# fwht_reorder

Output reorder buffer for the SDF Fast Walsh-Hadamard pipeline. It sits after the last butterfly stage and consumes that stage's serial output stream, which arrives in natural (Hadamard) order. It double-buffers each N-point block and replays it as an unbroken burst, in sequency (Walsh) order or in natural order. It is the reader side of the pipeline's output stream.

## Interface
- WIDTH, 16, sample width in bits; data is passed through unmodified.
- LGN, 3, log2 of transform length; N = 2^LGN points per block.
- ORDER, 1, output order: 1 = sequency (Walsh), 0 = natural (Hadamard).
- i_clk  in  1  clock.
- i_reset  in  1  reset: synchronous, active-high.
- i_data  in  WIDTH  sample from the final butterfly stage.
- i_valid  in  1  i_data is valid this cycle. Gaps are allowed; there is no backpressure.
- o_data  out  WIDTH  reordered sample; reset value 0.
- o_valid  out  1  o_data is valid; reset value 0.
- o_last  out  1  high with the final sample (k = N-1) of each output block; reset value 0.
- o_busy  out  1  high while a block is being read out; reset value 0.

## Operation
- Memory is 2N words, split into two banks of N. Write bank select wbank resets to 0.
- Write side:
  - Each cycle with i_valid=1 writes i_data to address {wbank, wcnt}, then increments wcnt (LGN bits).
  - When wcnt wraps from N-1 to 0, the block is complete. In that same cycle: toggle wbank, and pulse the internal start flag with rbank set to the just-filled bank.
- Read side FSM:
  - IDLE → READ when start is seen.
  - In READ, rcnt k runs 0..N-1, one per cycle, unconditionally. The read address is {rbank, map(k)}.
  - READ → IDLE after k = N-1 is issued. The exception is the case below.
  - If start arrives in the same cycle that k = N-1 is issued, go directly to READ with k = 0 and the new rbank. The output has no bubble.
- Index map:
  - ORDER=1: map(k) = bitrev_LGN(k ^ (k >> 1)), i.e. Gray code then bit reversal.
  - ORDER=0: map(k) = k.
- Rate argument: the input runs at most one sample per cycle and the output at exactly one per cycle. Reading a bank always finishes no later than the cycle in which the other bank fills, so no overflow is possible and no flag exists for it.
- Simultaneous write and read of the same address cannot occur, because the two sides always use opposite banks.
- Reset mid-operation:
  - Any partial input block is discarded.
  - An in-flight burst is aborted. o_valid, o_last and o_busy are 0 from the cycle after reset is sampled.
  - wcnt, rcnt, wbank and the FSM return to 0/IDLE.
  - Memory contents are not cleared.

## Timing
- The memory read is registered, giving 1 cycle of read latency.
- If the last sample of a block is accepted in cycle t:
  - address k=0 is issued in cycle t+1;
  - o_valid is high in cycles t+2 .. t+N+1;
  - o_last is high in cycle t+N+1.
- With continuous input, first sample in to first sample out is N+1 cycles.
- o_busy is high in cycles t+1 .. t+N+1.
- With back-to-back continuous blocks, o_valid stays high permanently after the first burst starts.

## Structure
- Shared package fwht_pkg holds:
  - the default LGN and WIDTH constants;
  - the function walsh_index(k, lgn), the Gray-code plus bit-reverse map, reused by the reference model and any future sequency-ordered blocks.
- One sub-module: reorder_ram, a simple dual-port RAM of 2N × WIDTH with one write port and one registered read port, inferable as block RAM.
- The FSM, counters and bank logic live in fwht_reorder.

## Test plan
- **Sequency order:** LGN=3, ORDER=1, continuous input 0..7 → o_data 0,4,6,2,3,7,5,1. o_valid is high 2 cycles after sample 7 is accepted; o_last is high on the 1.
- **Natural order:** LGN=3, ORDER=0, continuous input 10..17 → o_data 10..17 in order, with the same timing.
- **Gapped input:** i_valid pattern 1,0,0,1,… with samples 0..7 → output identical to the continuous case; the burst starts 2 cycles after the 8th valid sample and has no gaps.
- **Back-to-back blocks:** three blocks 0..7, 8..15, 16..23 driven continuously → 24 consecutive o_valid cycles with permuted values per block (…,1, then 8,12,14,10,…). o_last is high every 8th cycle and there is no bubble at the bank swap.
- **Reset mid-burst:** assert i_reset for 1 cycle during output k=3 → o_valid=0 from the next cycle. A new block 0..7 afterwards produces a clean 0,4,6,2,3,7,5,1.
- **Reset mid-fill:** assert i_reset after 5 samples, then send 8 new samples 20..27 → output 20,24,26,22,23,27,25,21 only, with no stale data.
